hazard_ctrl: RTL and testbench

- Parametrised successor to the combinational hazard unit of the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Keeps MEM/WB operand forwarding as before.
- Adds registered stall/flush sequencing:
  - multi-cycle load-use bubbles;
  - multi-cycle execute-unit wait (mul/div handshake);
  - multi-cycle front-end flush after a taken branch, for fetch memories with latency.
- Sits beside the pipeline registers and drives their stall/flush enables.

---
 rtl/hazard_ctrl_pkg.sv | 26 ++
 rtl/hazard_ctrl_fwd_select.sv | 25 ++
 rtl/hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects, FSM states,
// the stall counter type and the bundled stall/flush control word.
package hazard_ctrl_pkg;

    localparam logic [1:0] RS_DATA = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] LOAD_STALL = 2'd1;
    localparam logic [1:0] MC_WAIT    = 2'd2;
    localparam logic [1:0] FLUSH      = 2'd3;

    localparam int CNT_W = $clog2(4);
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic pc_stall;
        logic fe_stall;
        logic ex_stall;
        logic flush_fe;
        logic flush_dec;
        logic flush_ex;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Per-source EX operand forwarding select; MEM result wins over WB, and x0 is
// never forwarded.
module fwd_select
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr_mem,
    input  logic                  rd_write_mem,
    input  logic [REG_ADDR_W-1:0] rd_addr_wb,
    input  logic                  rd_write_wb,
    output logic [1:0]            sel
);

    always_comb begin
        sel = RS_DATA;
        if (rd_write_mem && (rd_addr_mem != '0) && (rs_addr == rd_addr_mem)) begin
            sel = FWD_MEM;
        end else if (rd_write_wb && (rd_addr_wb != '0) && (rs_addr == rd_addr_wb)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding plus registered
// load-use / mul-div / branch-flush sequencing. Define HAZARD_PERF_EN for perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int FLUSH_EXTRA  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_addr_decode,
    input  logic [REG_ADDR_W-1:0] rs2_addr_decode,
    input  logic                  rs1_use_decode,
    input  logic                  rs2_use_decode,
    input  logic [REG_ADDR_W-1:0] rs1_addr_execute,
    input  logic [REG_ADDR_W-1:0] rs2_addr_execute,
    input  logic [REG_ADDR_W-1:0] rd_addr_execute,
    input  logic                  load_execute,
    input  logic [REG_ADDR_W-1:0] rd_addr_mem,
    input  logic                  rd_write_mem,
    input  logic [REG_ADDR_W-1:0] rd_addr_wb,
    input  logic                  rd_write_wb,
    input  logic                  taken,
    input  logic                  mc_start,
    input  logic                  mc_done,
    output logic [1:0]            forward_control_src1,
    output logic [1:0]            forward_control_src2,
    output logic                  pc_stall,
    output logic                  fe_stall,
    output logic                  ex_stall,
    output logic                  flush_fe,
    output logic                  flush_dec,
    output logic                  flush_ex
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_load_stalls,
    output logic [31:0]           perf_mc_stalls,
    output logic [31:0]           perf_flushes
`endif
);

    if (LOAD_LATENCY < 1 || LOAD_LATENCY > 3) begin : g_bad_load_latency
        $error("hazard_ctrl: LOAD_LATENCY must be in 1..3");
    end
    if (FLUSH_EXTRA < 0 || FLUSH_EXTRA > 3) begin : g_bad_flush_extra
        $error("hazard_ctrl: FLUSH_EXTRA must be in 0..3");
    end

    logic [1:0] sel1, sel2;
    logic [1:0] state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    hz_ctrl_t   ctl;
    logic       rs1_hit, rs2_hit, load_use;

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd1 (
        .rs_addr      (rs1_addr_execute),
        .rd_addr_mem  (rd_addr_mem),
        .rd_write_mem (rd_write_mem),
        .rd_addr_wb   (rd_addr_wb),
        .rd_write_wb  (rd_write_wb),
        .sel          (sel1)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd2 (
        .rs_addr      (rs2_addr_execute),
        .rd_addr_mem  (rd_addr_mem),
        .rd_write_mem (rd_write_mem),
        .rd_addr_wb   (rd_addr_wb),
        .rd_write_wb  (rd_write_wb),
        .sel          (sel2)
    );

    assign rs1_hit  = rs1_use_decode && (rs1_addr_decode == rd_addr_execute);
    assign rs2_hit  = rs2_use_decode && (rs2_addr_decode == rd_addr_execute);
    assign load_use = load_execute && (rd_addr_execute != '0) && (rs1_hit || rs2_hit);

    // Control decode: state plus current inputs, no added latency
    always_comb begin
        ctl     = '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mc_start && !mc_done) begin
                    ctl.pc_stall = 1'b1;
                    ctl.fe_stall = 1'b1;
                    ctl.ex_stall = 1'b1;
                    ctl.flush_ex = 1'b1;
                    state_d      = MC_WAIT;
                end else if (mc_start) begin
                    // op completes in its first EX cycle: no stall
                end else if (taken) begin
                    ctl.flush_fe  = 1'b1;
                    ctl.flush_dec = 1'b1;
                    if (FLUSH_EXTRA > 0) begin
                        cnt_d   = cnt_t'(FLUSH_EXTRA);
                        state_d = FLUSH;
                    end
                end else if (load_use) begin
                    ctl.pc_stall  = 1'b1;
                    ctl.fe_stall  = 1'b1;
                    ctl.flush_dec = 1'b1;
                    if (LOAD_LATENCY > 1) begin
                        cnt_d   = cnt_t'(LOAD_LATENCY - 1);
                        state_d = LOAD_STALL;
                    end
                end
            end
            LOAD_STALL: begin
                ctl.pc_stall  = 1'b1;
                ctl.fe_stall  = 1'b1;
                ctl.flush_dec = 1'b1;
                cnt_d         = cnt_q - 1'b1;
                if (cnt_q <= cnt_t'(1)) state_d = IDLE;
            end
            MC_WAIT: begin
                // mc_start dropping without mc_done is an abort of a flushed op
                if (mc_done || !mc_start) begin
                    state_d = IDLE;
                end else begin
                    ctl.pc_stall = 1'b1;
                    ctl.fe_stall = 1'b1;
                    ctl.ex_stall = 1'b1;
                    ctl.flush_ex = 1'b1;
                end
            end
            FLUSH: begin
                ctl.flush_fe = 1'b1;
                if (taken) begin
                    ctl.flush_dec = 1'b1;
                    cnt_d         = cnt_t'(FLUSH_EXTRA);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= cnt_t'(1)) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign forward_control_src1 = rst ? RS_DATA : sel1;
    assign forward_control_src2 = rst ? RS_DATA : sel2;
    assign pc_stall  = ctl.pc_stall  && !rst;
    assign fe_stall  = ctl.fe_stall  && !rst;
    assign ex_stall  = ctl.ex_stall  && !rst;
    assign flush_fe  = ctl.flush_fe  && !rst;
    assign flush_dec = ctl.flush_dec && !rst;
    assign flush_ex  = ctl.flush_ex  && !rst;

    // State register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Load stalls hold PC without EX; a taken branch is flush_fe with flush_dec
    logic load_act, mc_act, flush_evt;
    assign load_act  = ctl.pc_stall && !ctl.ex_stall;
    assign mc_act    = ctl.ex_stall;
    assign flush_evt = ctl.flush_fe && ctl.flush_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_stalls <= '0;
            perf_mc_stalls   <= '0;
            perf_flushes     <= '0;
        end else begin
            if (load_act)  perf_load_stalls <= sat_inc(perf_load_stalls);
            if (mc_act)    perf_mc_stalls   <= sat_inc(perf_mc_stalls);
            if (flush_evt) perf_flushes     <= sat_inc(perf_flushes);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (LOAD_LATENCY=2, FLUSH_EXTRA=2): vector table
// plus hand-written multi-cycle sequences.
module tb_hazard_ctrl;

    localparam int LL = 2;
    localparam int FE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_addr_decode, rs2_addr_decode;
    logic       rs1_use_decode, rs2_use_decode;
    logic [4:0] rs1_addr_execute, rs2_addr_execute, rd_addr_execute;
    logic       load_execute;
    logic [4:0] rd_addr_mem, rd_addr_wb;
    logic       rd_write_mem, rd_write_wb;
    logic       taken, mc_start, mc_done;
    logic [1:0] forward_control_src1, forward_control_src2;
    logic       pc_stall, fe_stall, ex_stall, flush_fe, flush_dec, flush_ex;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_load_stalls, perf_mc_stalls, perf_flushes;
`endif

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(LL), .FLUSH_EXTRA(FE)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rs1_addr_decode      (rs1_addr_decode),
        .rs2_addr_decode      (rs2_addr_decode),
        .rs1_use_decode       (rs1_use_decode),
        .rs2_use_decode       (rs2_use_decode),
        .rs1_addr_execute     (rs1_addr_execute),
        .rs2_addr_execute     (rs2_addr_execute),
        .rd_addr_execute      (rd_addr_execute),
        .load_execute         (load_execute),
        .rd_addr_mem          (rd_addr_mem),
        .rd_write_mem         (rd_write_mem),
        .rd_addr_wb           (rd_addr_wb),
        .rd_write_wb          (rd_write_wb),
        .taken                (taken),
        .mc_start             (mc_start),
        .mc_done              (mc_done),
        .forward_control_src1 (forward_control_src1),
        .forward_control_src2 (forward_control_src2),
        .pc_stall             (pc_stall),
        .fe_stall             (fe_stall),
        .ex_stall             (ex_stall),
        .flush_fe             (flush_fe),
        .flush_dec            (flush_dec),
        .flush_ex             (flush_ex)
`ifdef HAZARD_PERF_EN
        ,
        .perf_load_stalls     (perf_load_stalls),
        .perf_mc_stalls       (perf_mc_stalls),
        .perf_flushes         (perf_flushes)
`endif
    );

    // ctl bit order: {pc_stall, fe_stall, ex_stall, flush_fe, flush_dec, flush_ex}
    typedef struct {
        string      nm;
        logic [4:0] r1d, r2d;
        logic       u1, u2;
        logic [4:0] r1e, r2e, rde;
        logic       ld;
        logic [4:0] rdm;
        logic       wm;
        logic [4:0] rdw;
        logic       ww;
        logic       tk, mcs, mcd;
        logic [1:0] f1, f2;
        logic [5:0] ctl;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl[NV];

    task automatic clear_inputs();
        rs1_addr_decode  = '0; rs2_addr_decode  = '0;
        rs1_use_decode   = 1'b0; rs2_use_decode = 1'b0;
        rs1_addr_execute = '0; rs2_addr_execute = '0; rd_addr_execute = '0;
        load_execute     = 1'b0;
        rd_addr_mem      = '0; rd_write_mem = 1'b0;
        rd_addr_wb       = '0; rd_write_wb  = 1'b0;
        taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        rs1_addr_decode  = v.r1d; rs2_addr_decode = v.r2d;
        rs1_use_decode   = v.u1;  rs2_use_decode  = v.u2;
        rs1_addr_execute = v.r1e; rs2_addr_execute = v.r2e; rd_addr_execute = v.rde;
        load_execute     = v.ld;
        rd_addr_mem      = v.rdm; rd_write_mem = v.wm;
        rd_addr_wb       = v.rdw; rd_write_wb  = v.ww;
        taken = v.tk; mc_start = v.mcs; mc_done = v.mcd;
    endtask

    // Called at a negedge with inputs applied; checks, then moves to next negedge
    task automatic step_chk(input string nm, input logic [1:0] f1, input logic [1:0] f2,
                            input logic [5:0] c);
        logic [9:0] act, exp;
        #1;
        act = {forward_control_src1, forward_control_src2,
               pc_stall, fe_stall, ex_stall, flush_fe, flush_dec, flush_ex};
        exp = {f1, f2, c};
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got f1=%0d f2=%0d ctl=%b, want f1=%0d f2=%0d ctl=%b",
                     nm, act[9:8], act[7:6], act[5:0], f1, f2, c);
        end
        @(negedge clk);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          nm            r1d    r2d    u1    u2    r1e    r2e    rde    ld    rdm    wm    rdw    ww    tk    mcs   mcd   f1    f2    ctl
        tbl[0]  = '{"fwd_mem",    5'd0,  5'd0,  1'b0, 1'b0, 5'd5,  5'd0,  5'd0,  1'b0, 5'd5,  1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 6'b000000};
        tbl[1]  = '{"fwd_wb",     5'd0,  5'd0,  1'b0, 1'b0, 5'd5,  5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 6'b000000};
        tbl[2]  = '{"fwd_x0",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b000000};
        tbl[3]  = '{"fwd_mix",    5'd0,  5'd0,  1'b0, 1'b0, 5'd3,  5'd9,  5'd0,  1'b0, 5'd9,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 6'b000000};
        tbl[4]  = '{"fwd_memoff", 5'd0,  5'd0,  1'b0, 1'b0, 5'd4,  5'd4,  5'd0,  1'b0, 5'd4,  1'b0, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 6'b000000};
        tbl[5]  = '{"fwd_alloff", 5'd0,  5'd0,  1'b0, 1'b0, 5'd4,  5'd4,  5'd0,  1'b0, 5'd4,  1'b0, 5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b000000};
        tbl[6]  = '{"lu_nouse",   5'd0,  5'd7,  1'b0, 1'b0, 5'd0,  5'd0,  5'd7,  1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b000000};
        tbl[7]  = '{"lu_rd0",     5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b000000};
        tbl[8]  = '{"lu_noload",  5'd0,  5'd7,  1'b0, 1'b1, 5'd0,  5'd0,  5'd7,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b000000};
        tbl[9]  = '{"lu_rs2_c1",  5'd0,  5'd7,  1'b0, 1'b1, 5'd0,  5'd0,  5'd7,  1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b110010};
        tbl[10] = '{"lu_rs2_c2",  5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b110010};
        tbl[11] = '{"lu_rs2_end", 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b000000};
        tbl[12] = '{"lu_rs1_c1",  5'd12, 5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  5'd12, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b110010};
        tbl[13] = '{"lu_rs1_tk",  5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 6'b110010};
        tbl[14] = '{"lu_rs1_end", 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b000000};
        tbl[15] = '{"mc_oneshot", 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 6'b000000};
        tbl[16] = '{"tk_over_lu", 5'd6,  5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  5'd6,  1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 6'b000110};
        tbl[17] = '{"fl_lu_c2",   5'd6,  5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  5'd6,  1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b000100};
        tbl[18] = '{"fl_lu_c3",   5'd6,  5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  5'd6,  1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b000100};
        tbl[19] = '{"fl_end",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b000000};
        tbl[20] = '{"mc_over_tk", 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 6'b111001};
        tbl[21] = '{"mc_done1",   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 6'b000000};
        tbl[22] = '{"mc_after",   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 6'b000000};

        // Reset: outputs forced quiet even with matching/stalling inputs
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rs1_addr_execute = 5'd5; rd_addr_mem = 5'd5; rd_write_mem = 1'b1; mc_start = 1'b1;
        step_chk("reset_quiet", 2'd0, 2'd0, 6'b000000);
        clear_inputs();
        rst = 1'b0;
        step_chk("reset_idle", 2'd0, 2'd0, 6'b000000);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i]);
            step_chk(tbl[i].nm, tbl[i].f1, tbl[i].f2, tbl[i].ctl);
        end

        // Multi-cycle op: done arrives 5 cycles after start; taken inside is ignored
        clear_inputs();
        mc_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            taken = (i == 2);
            step_chk($sformatf("mc_wait_%0d", i), 2'd0, 2'd0, 6'b111001);
        end
        taken = 1'b0; mc_done = 1'b1;
        step_chk("mc_done_cyc", 2'd0, 2'd0, 6'b000000);
        clear_inputs();
        step_chk("mc_post", 2'd0, 2'd0, 6'b000000);

        // Taken during FLUSH reloads the counter and re-asserts flush_dec
        taken = 1'b1;
        step_chk("fl_tk0", 2'd0, 2'd0, 6'b000110);
        taken = 1'b0;
        step_chk("fl_c1", 2'd0, 2'd0, 6'b000100);
        taken = 1'b1;
        step_chk("fl_retk", 2'd0, 2'd0, 6'b000110);
        taken = 1'b0;
        step_chk("fl_r1", 2'd0, 2'd0, 6'b000100);
        step_chk("fl_r2", 2'd0, 2'd0, 6'b000100);
        step_chk("fl_r_end", 2'd0, 2'd0, 6'b000000);

        // Abort: mc_start drops without mc_done, FSM must be back in IDLE
        mc_start = 1'b1;
        step_chk("ab_c0", 2'd0, 2'd0, 6'b111001);
        step_chk("ab_c1", 2'd0, 2'd0, 6'b111001);
        mc_start = 1'b0;
        step_chk("ab_drop", 2'd0, 2'd0, 6'b000000);
        rs1_addr_decode = 5'd3; rs1_use_decode = 1'b1; rd_addr_execute = 5'd3; load_execute = 1'b1;
        step_chk("ab_lu_c1", 2'd0, 2'd0, 6'b110010);
        clear_inputs();
        step_chk("ab_lu_c2", 2'd0, 2'd0, 6'b110010);
        step_chk("ab_lu_end", 2'd0, 2'd0, 6'b000000);

        // Reset in the 2nd MC_WAIT cycle: quiet during reset, IDLE afterwards
        mc_start = 1'b1;
        step_chk("rs_mc0", 2'd0, 2'd0, 6'b111001);
        rst = 1'b1;
        rs1_addr_execute = 5'd5; rd_addr_mem = 5'd5; rd_write_mem = 1'b1;
        step_chk("rs_mid", 2'd0, 2'd0, 6'b000000);
        rst = 1'b0;
        clear_inputs();
        rs1_addr_decode = 5'd3; rs1_use_decode = 1'b1; rd_addr_execute = 5'd3; load_execute = 1'b1;
        step_chk("rs_after_c1", 2'd0, 2'd0, 6'b110010);
        clear_inputs();
        step_chk("rs_after_c2", 2'd0, 2'd0, 6'b110010);
        step_chk("rs_after_end", 2'd0, 2'd0, 6'b000000);

`ifdef HAZARD_PERF_EN
        rst = 1'b1;
        clear_inputs();
        step_chk("perf_rst", 2'd0, 2'd0, 6'b000000);
        rst = 1'b0;
        for (int e = 0; e < 3; e++) begin
            rs2_addr_decode = 5'd7; rs2_use_decode = 1'b1; rd_addr_execute = 5'd7; load_execute = 1'b1;
            step_chk($sformatf("perf_lu%0d_c1", e), 2'd0, 2'd0, 6'b110010);
            clear_inputs();
            step_chk($sformatf("perf_lu%0d_c2", e), 2'd0, 2'd0, 6'b110010);
            step_chk($sformatf("perf_lu%0d_end", e), 2'd0, 2'd0, 6'b000000);
        end
        taken = 1'b1;
        step_chk("perf_tk", 2'd0, 2'd0, 6'b000110);
        taken = 1'b0;
        step_chk("perf_fl1", 2'd0, 2'd0, 6'b000100);
        step_chk("perf_fl2", 2'd0, 2'd0, 6'b000100);
        #1;
        chk32("perf_load_stalls", perf_load_stalls, 32'd3 * LL);
        chk32("perf_flushes", perf_flushes, 32'd1);
        chk32("perf_mc_stalls", perf_mc_stalls, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
